// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor and misprediction resolver for the 5-stage RV32I
// core. A direct-mapped branch target buffer (BTB) with 2-bit saturating
// counters provides a taken/target prediction for the fetch PC. In EX, the
// actual outcome (BranchE) is compared with the prediction carried down the
// pipeline. On a mismatch, a flush/redirect is raised. The BTB entry for PCE is
// also trained.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   PCF             : fetch PC used for lookup
//   PredTakenF      : predicted taken for PCF
//   PredTargetF     : predicted next fetch PC (PCF+4 when not taken)
//   StallE          : EX stage held; suppresses resolve, training, statistics
//   BranchTypeE     : 0/7 = not a conditional branch, 1..6 = BEQ..BGEU
//   PCE, BrTargetE  : PC and computed target of the EX instruction
//   BranchE         : actual branch outcome (1 = taken)
//   PredTakenE/PredTargetE : IF prediction carried to EX
//   MispredictE     : flush IF/ID and redirect fetch to CorrectPCE
//   CorrectPCE      : redirect address (always driven)
//   BranchCount     : resolved conditional branches (wraps)
//   MispredCount    : mispredictions (wraps)
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        StallE,
  input  logic [2:0]  BranchTypeE,
  input  logic [31:0] PCE,
  input  logic [31:0] BrTargetE,
  input  logic        BranchE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] CorrectPCE,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredCount
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  // BTB storage
  logic [ENTRIES-1:0]  valid_q;
  logic [1:0]          cnt_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];

  // Statistics
  logic [31:0] branch_cnt_q;
  logic [31:0] branch_cnt_d;
  logic [31:0] mispred_cnt_q;
  logic [31:0] mispred_cnt_d;

  // Lookup side
  logic [INDEX_BITS-1:0] idx_f_s;
  logic [TAG_BITS-1:0]   tag_f_s;
  logic                  hit_f_s;

  // Resolve side
  logic [INDEX_BITS-1:0] idx_e_s;
  logic [TAG_BITS-1:0]   tag_e_s;
  logic                  hit_e_s;
  logic                  is_cond_s;
  logic                  resolve_s;
  logic                  we_s;
  logic [1:0]            cnt_d;
  logic [31:0]           target_d;

  assign idx_f_s = PCF[INDEX_BITS+1:2];
  assign tag_f_s = PCF[31:INDEX_BITS+2];
  assign idx_e_s = PCE[INDEX_BITS+1:2];
  assign tag_e_s = PCE[31:INDEX_BITS+2];

  // Fetch-side lookup: purely combinational from the registered table, no
  // bypass of a same-cycle update.
  always_comb begin
    hit_f_s     = valid_q[idx_f_s] && (tag_q[idx_f_s] == tag_f_s);
    PredTakenF  = 1'b0;
    PredTargetF = PCF + 32'd4;
    if (hit_f_s && cnt_q[idx_f_s][1]) begin
      PredTakenF  = 1'b1;
      PredTargetF = target_q[idx_f_s];
    end else begin
      PredTakenF  = 1'b0;
      PredTargetF = PCF + 32'd4;
    end
  end

  // EX-side resolve: misprediction detection, redirect address and the
  // next-state of the BTB entry addressed by PCE.
  always_comb begin
    // BranchTypeE 0 and 7 are both "not a conditional branch".
    is_cond_s  = (BranchTypeE != 3'd0) && (BranchTypeE != 3'd7);
    resolve_s  = is_cond_s && !StallE;
    hit_e_s    = valid_q[idx_e_s] && (tag_q[idx_e_s] == tag_e_s);
    CorrectPCE = BranchE ? BrTargetE : (PCE + 32'd4);

    // A taken branch is mispredicted if it was predicted not-taken or to a
    // different target; a not-taken branch only if it was predicted taken.
    MispredictE = resolve_s &&
                  ((BranchE && (!PredTakenE || (PredTargetE != BrTargetE))) ||
                   (!BranchE && PredTakenE));

    we_s     = 1'b0;
    cnt_d    = cnt_q[idx_e_s];
    target_d = target_q[idx_e_s];
    if (resolve_s) begin
      if (hit_e_s) begin
        we_s = 1'b1;
        if (BranchE) begin
          cnt_d    = (cnt_q[idx_e_s] == 2'b11) ? 2'b11 : (cnt_q[idx_e_s] + 2'd1);
          target_d = BrTargetE;
        end else begin
          cnt_d    = (cnt_q[idx_e_s] == 2'b00) ? 2'b00 : (cnt_q[idx_e_s] - 2'd1);
        end
      end else if (BranchE) begin
        // Allocate weakly taken, evicting whatever lived at this index.
        we_s     = 1'b1;
        cnt_d    = 2'b10;
        target_d = BrTargetE;
      end else begin
        we_s = 1'b0;
      end
    end else begin
      we_s = 1'b0;
    end

    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (resolve_s) begin
      branch_cnt_d  = branch_cnt_q + 32'd1;
      mispred_cnt_d = mispred_cnt_q + {31'd0, MispredictE};
    end else begin
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
    end
  end

  // Resettable state: valid bits, counters and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= 2'b01;
      end
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      if (we_s) begin
        valid_q[idx_e_s] <= 1'b1;
        cnt_q[idx_e_s]   <= cnt_d;
      end
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Tag/target payload: not reset (guarded by valid), but reset still wins
  // over a simultaneous training write.
  always_ff @(posedge clk) begin
    if (!rst && we_s) begin
      tag_q[idx_e_s]    <= tag_e_s;
      target_q[idx_e_s] <= target_d;
    end
  end

  assign BranchCount  = branch_cnt_q;
  assign MispredCount = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed bench for branch_predictor. Expected values are pushed to a
// scoreboard queue as each step is driven and popped/compared when the DUT
// outputs are sampled, 1 time unit after inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        StallE;
  logic [2:0]  BranchTypeE;
  logic [31:0] PCE;
  logic [31:0] BrTargetE;
  logic        BranchE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredictE;
  logic [31:0] CorrectPCE;
  logic [31:0] BranchCount;
  logic [31:0] MispredCount;

  branch_predictor #(.INDEX_BITS(6)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF),
    .PredTargetF(PredTargetF), .StallE(StallE), .BranchTypeE(BranchTypeE),
    .PCE(PCE), .BrTargetE(BrTargetE), .BranchE(BranchE),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .MispredictE(MispredictE), .CorrectPCE(CorrectPCE),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_mis++;
      $error("FAIL scoreboard_empty: observed %h expected <none>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_mis++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Compare fetch prediction and both statistics counters.
  task automatic chk_fetch_stats(input string t, input logic pt, input logic [31:0] ptg,
                                 input logic [31:0] bc, input logic [31:0] mc);
    push_exp({t, "_PredTakenF"}, {31'd0, pt});
    push_exp({t, "_PredTargetF"}, ptg);
    push_exp({t, "_BranchCount"}, bc);
    push_exp({t, "_MispredCount"}, mc);
    pop_cmp({31'd0, PredTakenF});
    pop_cmp(PredTargetF);
    pop_cmp(BranchCount);
    pop_cmp(MispredCount);
  endtask

  task automatic chk_ex(input string t, input logic mp, input logic [31:0] cpc);
    push_exp({t, "_MispredictE"}, {31'd0, mp});
    push_exp({t, "_CorrectPCE"}, cpc);
    pop_cmp({31'd0, MispredictE});
    pop_cmp(CorrectPCE);
  endtask

  task automatic idle();
    StallE      = 1'b0;
    BranchTypeE = 3'd0;
    PCE         = 32'h0;
    BrTargetE   = 32'h0;
    BranchE     = 1'b0;
    PredTakenE  = 1'b0;
    PredTargetE = 32'h0;
  endtask

  task automatic drive_br(input logic [2:0] bt, input logic [31:0] pce,
                          input logic [31:0] tgt, input logic tk,
                          input logic ptk, input logic [31:0] ptgt);
    StallE      = 1'b0;
    BranchTypeE = bt;
    PCE         = pce;
    BrTargetE   = tgt;
    BranchE     = tk;
    PredTakenE  = ptk;
    PredTargetE = ptgt;
  endtask

  initial begin
    rst = 1'b1;
    PCF = 32'h100;
    idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_fetch_stats("reset", 1'b0, 32'h104, 32'd0, 32'd0);

    // BEQ taken, predicted not-taken: allocate; same-cycle lookup sees old table.
    @(negedge clk);
    drive_br(3'd1, 32'h100, 32'h80, 1'b1, 1'b0, 32'h0);
    #1;
    chk_ex("alloc", 1'b1, 32'h80);
    push_exp("alloc_nobypass", 32'd0);
    pop_cmp({31'd0, PredTakenF});

    @(negedge clk);
    idle();
    #1;
    chk_fetch_stats("after_alloc", 1'b1, 32'h80, 32'd1, 32'd1);

    // Not taken twice: cnt 10 -> 01 -> 00.
    @(negedge clk);
    drive_br(3'd1, 32'h100, 32'h80, 1'b0, 1'b1, 32'h80);
    #1;
    chk_ex("nt1", 1'b1, 32'h104);
    @(negedge clk);
    drive_br(3'd1, 32'h100, 32'h80, 1'b0, 1'b0, 32'h0);
    #1;
    chk_ex("nt2", 1'b0, 32'h104);
    @(negedge clk);
    idle();
    #1;
    chk_fetch_stats("after_nt", 1'b0, 32'h104, 32'd3, 32'd2);

    // Train back up: 00 -> 01 -> 10 (both mispredicted as not-taken).
    @(negedge clk);
    drive_br(3'd1, 32'h100, 32'h80, 1'b1, 1'b0, 32'h0);
    #1;
    chk_ex("up1", 1'b1, 32'h80);
    @(negedge clk);
    drive_br(3'd1, 32'h100, 32'h80, 1'b1, 1'b0, 32'h0);
    #1;
    chk_ex("up2", 1'b1, 32'h80);
    @(negedge clk);
    idle();
    #1;
    chk_fetch_stats("after_up", 1'b1, 32'h80, 32'd5, 32'd4);

    // Predicted taken to 0x80, actual taken to 0x90: wrong target.
    @(negedge clk);
    drive_br(3'd3, 32'h100, 32'h90, 1'b1, 1'b1, 32'h80);
    #1;
    chk_ex("wrong_tgt", 1'b1, 32'h90);
    @(negedge clk);
    drive_br(3'd3, 32'h100, 32'h90, 1'b1, 1'b1, 32'h90);
    #1;
    chk_ex("right_tgt", 1'b0, 32'h90);
    @(negedge clk);
    idle();
    #1;
    chk_fetch_stats("after_tgt", 1'b1, 32'h90, 32'd7, 32'd5);

    // Non-branch types never mispredict nor count.
    @(negedge clk);
    drive_br(3'd0, 32'h100, 32'h90, 1'b0, 1'b1, 32'h90);
    #1;
    chk_ex("type0", 1'b0, 32'h104);
    @(negedge clk);
    drive_br(3'd7, 32'h100, 32'h90, 1'b0, 1'b1, 32'h90);
    #1;
    chk_ex("type7", 1'b0, 32'h104);
    @(negedge clk);
    idle();
    #1;
    chk_fetch_stats("after_nonbr", 1'b1, 32'h90, 32'd7, 32'd5);

    // BNE held by StallE for 3 cycles, then resolves once. 0x200 shares
    // index 0 with 0x100 and evicts it.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_br(3'd2, 32'h200, 32'h300, 1'b1, 1'b0, 32'h0);
      StallE = 1'b1;
      #1;
      chk_ex("stalled", 1'b0, 32'h300);
    end
    @(negedge clk);
    StallE = 1'b0;
    #1;
    chk_ex("unstall", 1'b1, 32'h300);
    @(negedge clk);
    idle();
    PCF = 32'h200;
    #1;
    chk_fetch_stats("after_stall", 1'b1, 32'h300, 32'd8, 32'd6);
    PCF = 32'h100;
    #1;
    chk_fetch_stats("evicted", 1'b0, 32'h104, 32'd8, 32'd6);

    // Mispredict counter wrap from a forced all-ones value.
    @(negedge clk);
    force dut.mispred_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.mispred_cnt_q;
    drive_br(3'd5, 32'h400, 32'h500, 1'b0, 1'b1, 32'h500);
    #1;
    chk_ex("wrap_mp", 1'b1, 32'h404);
    @(negedge clk);
    idle();
    PCF = 32'h400;
    #1;
    chk_fetch_stats("wrap", 1'b0, 32'h404, 32'd9, 32'd0);

    // Reset wins over a simultaneous taken resolve.
    @(negedge clk);
    drive_br(3'd1, 32'h500, 32'h600, 1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    chk_ex("rst_res", 1'b1, 32'h600);
    @(negedge clk);
    rst = 1'b0;
    idle();
    PCF = 32'h500;
    #1;
    chk_fetch_stats("rst_noalloc", 1'b0, 32'h504, 32'd0, 32'd0);
    PCF = 32'h200;
    #1;
    chk_fetch_stats("rst_cleared", 1'b0, 32'h204, 32'd0, 32'd0);

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
